remote_cmd_sched: RTL

Remote-side command scheduler sitting in front of `CommMaster`. It queues {cmd, data} requests from the remote controller logic, issues them one at a time to `CommMaster`, waits for the frame to go out and the copter's response to come back, and checks that response. Failed or timed-out commands are retried a bounded number of times before being dropped with an error flag.

---
 rtl/quad_pkg.sv | 33 +++
 rtl/cmd_fifo.sv | 56 +++++
 rtl/remote_cmd_sched.sv | 126 ++++++++++++
 3 files changed

// File: rtl/quad_pkg.sv
// Shared opcodes, response constants and types for the remote scheduler.
// Imported by cmd_fifo and remote_cmd_sched.
package quad_pkg;

   localparam logic [7:0] REQ_BATT  = 8'h01;
   localparam logic [7:0] SET_PTCH  = 8'h02;
   localparam logic [7:0] SET_ROLL  = 8'h03;
   localparam logic [7:0] SET_YAW   = 8'h04;
   localparam logic [7:0] SET_THRST = 8'h05;
   localparam logic [7:0] CALIBRATE = 8'h06;
   localparam logic [7:0] EMER_LAND = 8'h07;
   localparam logic [7:0] MTRS_OFF  = 8'h08;
   localparam logic [7:0] ACK       = 8'hA5;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_FRM,
      WAIT_RESP
   } sched_state_t;

   typedef struct packed {
      logic [7:0]  cmd;
      logic [15:0] data;
   } cmd_entry_t;

   // Battery replies carry a level, so any byte is acceptable there.
   function automatic logic resp_good(input logic [7:0] c,
                                      input logic [7:0] r);
      return (c == REQ_BATT) || (r == ACK);
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Circular command queue, DEPTH x 24-bit {cmd,data} entries.
// Ports: clk, rst_n, push/wdata in, pop in, head/full/empty out.
module cmd_fifo
   import quad_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic       pop,
   input  cmd_entry_t wdata,
   output cmd_entry_t head,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   cmd_entry_t     mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [CW-1:0]  count;
   logic           do_pop;
   logic           do_push;

   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a full queue still takes it.
   assign do_push = push && (!full || do_pop);

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/remote_cmd_sched.sv
// Queues {cmd,data} requests and issues them to CommMaster one at a time,
// checking each response with bounded retry on bad reply or timeout.
// Ports: push side (push/push_cmd/push_data/full/empty), CommMaster side
// (cmd/data/snd_cmd/frm_snt/resp/resp_rdy), status (busy/cmd_done/cmd_err/last_resp).
module remote_cmd_sched
   import quad_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int TIMEOUT   = 2_000_000,
   parameter int MAX_RETRY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  logic [7:0]  push_cmd,
   input  logic [15:0] push_data,
   output logic        full,
   output logic        empty,
   output logic [7:0]  cmd,
   output logic [15:0] data,
   output logic        snd_cmd,
   input  logic        frm_snt,
   input  logic [7:0]  resp,
   input  logic        resp_rdy,
   output logic        busy,
   output logic        cmd_done,
   output logic        cmd_err,
   output logic [7:0]  last_resp
);

   localparam int TW = $clog2(TIMEOUT);
   localparam int RW = $clog2(MAX_RETRY + 2);

   sched_state_t   state;
   logic [RW-1:0]  retry;
   logic [TW-1:0]  tmo;
   cmd_entry_t     head;
   cmd_entry_t     wdata;
   logic           pop;
   logic           good;
   logic           tmo_hit;
   logic           fail;
   logic           can_retry;

   assign wdata = '{cmd: push_cmd, data: push_data};

   cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata (wdata),
      .head  (head),
      .full  (full),
      .empty (empty)
   );

   assign cmd  = head.cmd;
   assign data = head.data;
   assign busy = (state != IDLE);

   // A response in the timeout cycle takes priority over the timeout.
   assign good      = resp_rdy && resp_good(head.cmd, resp);
   assign tmo_hit   = (tmo == TW'(TIMEOUT - 1));
   assign fail      = resp_rdy ? !good : tmo_hit;
   assign can_retry = (retry < RW'(MAX_RETRY));

   // Head stays put through retries; it leaves only on success or drop.
   assign pop = (state == WAIT_RESP) && (good || (fail && !can_retry));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         retry     <= '0;
         tmo       <= '0;
         snd_cmd   <= 1'b0;
         cmd_done  <= 1'b0;
         cmd_err   <= 1'b0;
         last_resp <= 8'h00;
      end else begin
         snd_cmd  <= 1'b0;
         cmd_done <= 1'b0;
         cmd_err  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!empty) begin
                  retry   <= '0;
                  snd_cmd <= 1'b1;
                  state   <= SEND;
               end
            end
            SEND: begin
               state <= WAIT_FRM;
            end
            WAIT_FRM: begin
               if (frm_snt) begin
                  tmo   <= '0;
                  state <= WAIT_RESP;
               end
            end
            WAIT_RESP: begin
               tmo <= tmo + 1'b1;
               if (good) begin
                  cmd_done  <= 1'b1;
                  last_resp <= resp;
                  state     <= IDLE;
               end else if (fail) begin
                  if (can_retry) begin
                     retry   <= retry + 1'b1;
                     snd_cmd <= 1'b1;
                     state   <= SEND;
                  end else begin
                     cmd_err <= 1'b1;
                     if (resp_rdy) begin
                        last_resp <= resp;
                     end
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
